// File: rtl/inst_loader_if.sv
// inst_loader_if: byte-stream input and instruction-memory write bundle for the loader
interface inst_loader_if #(parameter int ADDR_W = 11);
    logic [7:0]        i_byte;
    logic              i_byte_valid;
    logic              o_byte_ready;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [7:0]        o_wr_data;
    logic              o_cpu_hold;
    logic              o_done;
    logic              o_error;
    logic [ADDR_W:0]   o_byte_count;
    modport master (
        output i_byte, i_byte_valid,
        input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_cpu_hold, o_done, o_error, o_byte_count
    );
    modport slave (
        input  i_byte, i_byte_valid,
        output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_cpu_hold, o_done, o_error, o_byte_count
    );
endinterface

// File: rtl/inst_loader.sv
// inst_loader: frames a byte stream (len lo/hi, payload, checksum) into instruction-memory writes
module inst_loader #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input logic          i_clk,
    input logic          i_reset,
    inst_loader_if.slave bus
);
    localparam logic [2:0] S_LEN_LO = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CHK    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);
    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              hold_q, hold_d;
    logic              ready;
    logic              accept;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   count_nxt;
    assign ready     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CHK);
    assign accept    = bus.i_byte_valid && ready;
    assign len_full  = {bus.i_byte, len_q[7:0]};
    assign count_nxt = count_q + 1'b1;
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        sum_d     = sum_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        error_d   = error_q;
        if (accept) begin
            case (state_q)
                S_LEN_LO: begin
                    len_d   = {len_q[15:8], bus.i_byte};
                    state_d = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_d   = len_full;
                    state_d = (len_full > DEPTH16) ? S_ERR : (len_full == 16'd0) ? S_CHK : S_DATA;
                    error_d = len_full > DEPTH16;
                end
                S_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[ADDR_W-1:0];
                    wr_data_d = bus.i_byte;
                    sum_d     = sum_q + bus.i_byte;
                    count_d   = count_nxt;
                    state_d   = (16'(count_nxt) == len_q) ? S_CHK : S_DATA;
                end
                S_CHK: begin
                    done_d  = bus.i_byte == sum_q;
                    error_d = bus.i_byte != sum_q;
                    state_d = (bus.i_byte == sum_q) ? S_DONE : S_ERR;
                end
                default: state_d = state_q;
            endcase
        end
        hold_d = ~done_d;
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= S_LEN_LO;
            len_q     <= '0;
            sum_q     <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            hold_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            error_q   <= error_d;
            hold_q    <= hold_d;
        end
    end
    assign bus.o_byte_ready = ready;
    assign bus.o_wr_en      = wr_en_q;
    assign bus.o_wr_addr    = wr_addr_q;
    assign bus.o_wr_data    = wr_data_q;
    assign bus.o_cpu_hold   = hold_q;
    assign bus.o_done       = done_q;
    assign bus.o_error      = error_q;
    assign bus.o_byte_count = count_q;
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed frames with hand-computed writes and flag expectations
module tb_inst_loader;
    logic i_clk;
    logic i_reset;
    int vectors;
    int miscompares;
    logic [7:0] fr[$];
    inst_loader_if #(.ADDR_W(11)) bus ();
    inst_loader #(.ADDR_W(11), .DEPTH(2048)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic rst_dut();
        bus.i_byte_valid = 1'b0;
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        chk("rst_ready", 32'(bus.o_byte_ready), 32'd1);
        chk("rst_wr_en", 32'(bus.o_wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.o_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.o_wr_data), 32'd0);
        chk("rst_hold", 32'(bus.o_cpu_hold), 32'd1);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_error", 32'(bus.o_error), 32'd0);
        chk("rst_count", 32'(bus.o_byte_count), 32'd0);
    endtask
    task automatic send(input logic [7:0] b, input bit pay, input int addr, input bit rnd);
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                bus.i_byte_valid = 1'b0;
                bus.i_byte = 8'($urandom);
                @(posedge i_clk);
                #1;
                chk("idle_wr_en", 32'(bus.o_wr_en), 32'd0);
            end
        end
        bus.i_byte = b;
        bus.i_byte_valid = 1'b1;
        chk("ready", 32'(bus.o_byte_ready), 32'd1);
        @(posedge i_clk);
        #1;
        chk("wr_en", 32'(bus.o_wr_en), 32'(pay));
        if (pay) begin
            chk("wr_addr", 32'(bus.o_wr_addr), 32'(addr));
            chk("wr_data", 32'(bus.o_wr_data), 32'(b));
        end
    endtask
    task automatic frame(input bit rnd);
        int len;
        int n;
        len = int'({fr[1], fr[0]});
        n = (len > 2048) ? 2 : fr.size();
        for (int i = 0; i < n; i++)
            send(fr[i], (i >= 2) && (i < 2 + len), i - 2, rnd);
        bus.i_byte_valid = 1'b0;
    endtask
    task automatic flags(input bit d, input bit e, input int cnt);
        chk("done", 32'(bus.o_done), 32'(d));
        chk("error", 32'(bus.o_error), 32'(e));
        chk("hold", 32'(bus.o_cpu_hold), 32'(!d));
        chk("ready_end", 32'(bus.o_byte_ready), 32'(!(d || e)));
        chk("count", 32'(bus.o_byte_count), 32'(cnt));
    endtask
    task automatic ignored(input int cnt);
        bus.i_byte = 8'h55;
        bus.i_byte_valid = 1'b1;
        repeat (3) begin
            @(posedge i_clk);
            #1;
            chk("post_wr_en", 32'(bus.o_wr_en), 32'd0);
            chk("post_count", 32'(bus.o_byte_count), 32'(cnt));
        end
        bus.i_byte_valid = 1'b0;
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        vectors = 0;
        miscompares = 0;
        i_reset = 1'b0;
        bus.i_byte = 8'h00;
        bus.i_byte_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        rst_dut();
        fr = {8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        frame(1'b0);
        flags(1'b1, 1'b0, 4);
        ignored(4);
        rst_dut();
        fr = {8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
        frame(1'b0);
        flags(1'b0, 1'b1, 4);
        ignored(4);
        rst_dut();
        fr = {8'h01, 8'h08};
        frame(1'b0);
        flags(1'b0, 1'b1, 0);
        ignored(0);
        rst_dut();
        fr = {8'h00, 8'h00, 8'h00};
        frame(1'b0);
        flags(1'b1, 1'b0, 0);
        rst_dut();
        fr = {8'h00, 8'h00, 8'h01};
        frame(1'b0);
        flags(1'b0, 1'b1, 0);
        rst_dut();
        fr = {8'h00, 8'h08};
        repeat (2048) fr.push_back(8'h01);
        fr.push_back(8'h00);
        frame(1'b1);
        flags(1'b1, 1'b0, 2048);
        rst_dut();
        send(8'h04, 1'b0, 0, 1'b0);
        send(8'h00, 1'b0, 0, 1'b0);
        send(8'h11, 1'b1, 0, 1'b0);
        send(8'h22, 1'b1, 1, 1'b0);
        bus.i_byte_valid = 1'b0;
        chk("mid_count", 32'(bus.o_byte_count), 32'd2);
        rst_dut();
        fr = {8'h02, 8'h00, 8'hAA, 8'hBB, 8'h65};
        frame(1'b0);
        flags(1'b1, 1'b0, 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
